// File: rtl/hit_judge_ctrl.sv
// Rhythm-game timing-window judge: times early/perfect/late windows per note and issues
// one-cycle judgement codes plus a saturating combo. Optional macro: JUDGE_AUTOPLAY_EN.
module hit_judge_ctrl #(
    parameter int GOOD_WIN    = 4,
    parameter int PERFECT_WIN = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       note_valid,
    input  logic       btn,
    output logic [1:0] judge,
    output logic       judge_valid,
    output logic [7:0] combo,
    output logic       busy,
    output logic       overrun_err
);

    localparam int MAX_WIN = (GOOD_WIN > PERFECT_WIN) ? GOOD_WIN : PERFECT_WIN;
    localparam int CW      = $clog2(MAX_WIN + 1);
    localparam logic [CW-1:0] GOOD_LAST    = CW'(GOOD_WIN - 1);
    localparam logic [CW-1:0] PERFECT_LAST = CW'(PERFECT_WIN - 1);

    typedef enum logic [1:0] {IDLE, EARLY, PERFECT, LATE} state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          pending, pending_d;
    logic          overrun_d;
    logic          btn_q;
    logic          press;
    logic          autoplay;
    logic          win_end;
    logic          fire;
    logic [1:0]    code;
    logic [7:0]    combo_d;

`ifdef JUDGE_AUTOPLAY_EN
    // Attract mode: the button is ignored and every note scores perfect on PERFECT entry.
    assign press    = 1'b0;
    assign autoplay = 1'b1;
`else
    assign press    = btn & ~btn_q;
    assign autoplay = 1'b0;
`endif

    assign win_end = (state == PERFECT) ? (cnt == PERFECT_LAST) : (cnt == GOOD_LAST);

    // State register plus all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            pending     <= 1'b0;
            btn_q       <= 1'b0;
            judge       <= 2'b00;
            judge_valid <= 1'b0;
            combo       <= 8'd0;
            overrun_err <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            pending     <= pending_d;
            btn_q       <= btn;
            judge       <= fire ? code : 2'b00;
            judge_valid <= fire;
            combo       <= combo_d;
            overrun_err <= overrun_d;
        end
    end

    // Next-state logic. A press outranks a same-edge window advance.
    always_comb begin
        // NOTE: defaulting every comb output first prevents latch inference on
        // paths that do not assign it.
        state_d   = state;
        cnt_d     = cnt;
        pending_d = pending;
        overrun_d = overrun_err;
        if (state == IDLE) begin
            if (note_valid || pending) begin
                state_d   = EARLY;
                cnt_d     = '0;
                // A pending note is consumed; a simultaneous fresh note takes its slot.
                pending_d = pending & note_valid;
            end
        end else begin
            if (note_valid) begin
                pending_d = 1'b1;
                if (pending) overrun_d = 1'b1;
            end
            if (fire) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else if (tick) begin
                if (win_end) begin
                    cnt_d = '0;
                    unique case (state)
                        EARLY:   state_d = PERFECT;
                        PERFECT: state_d = LATE;
                        default: state_d = IDLE;
                    endcase
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
        end
    end

    // Judgement decode and combo update.
    always_comb begin
        fire = 1'b0;
        code = 2'b00;
        unique case (state)
            EARLY:   if (press) begin fire = 1'b1; code = 2'b01; end
            PERFECT: if (press || autoplay) begin fire = 1'b1; code = 2'b11; end
            LATE: begin
                if (press) begin
                    fire = 1'b1;
                    code = 2'b10;
                end else if (tick && win_end) begin
                    fire = 1'b1;
                    code = 2'b00;
                end
            end
            default: ;
        endcase

        combo_d = combo;
        if (fire) begin
            if (code == 2'b00)       combo_d = 8'd0;
            else if (combo != 8'hFF) combo_d = combo + 8'd1;
        end

        busy = (state != IDLE);
    end

endmodule

// File: tb/tb_hit_judge_ctrl.sv
// Self-checking bench for hit_judge_ctrl (GOOD_WIN=4, PERFECT_WIN=2, tick every cycle):
// a cycle-by-cycle vector table plus directed multi-cycle sequences.
module tb_hit_judge_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b1;
    logic       note_valid = 1'b0;
    logic       btn = 1'b0;
    logic [1:0] judge;
    logic       judge_valid;
    logic [7:0] combo;
    logic       busy;
    logic       overrun_err;

    int checks = 0;
    int errors = 0;

    hit_judge_ctrl #(.GOOD_WIN(4), .PERFECT_WIN(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .note_valid  (note_valid),
        .btn         (btn),
        .judge       (judge),
        .judge_valid (judge_valid),
        .combo       (combo),
        .busy        (busy),
        .overrun_err (overrun_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       note;
        logic       btn;
        logic [1:0] judge;
        logic       jv;
        logic [7:0] combo;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic n, input logic b, input logic [1:0] j,
                                input logic v, input logic [7:0] c, input logic bz);
        vec_t t;
        t.note = n; t.btn = b; t.judge = j; t.jv = v; t.combo = c; t.busy = bz;
        vecs.push_back(t);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after each rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [1:0] j, input logic v,
                             input logic [7:0] c, input logic bz);
        check({tag, " judge"}, judge, j);
        check({tag, " judge_valid"}, judge_valid, v);
        check({tag, " combo"}, combo, c);
        check({tag, " busy"}, busy, bz);
    endtask

    int         jv_seen;
    logic [7:0] exp_combo;

    initial begin
        // Perfect hit: press at the 5th edge after the note edge.
        add(1, 0, 2'b00, 0, 8'd0, 1);
        add(0, 0, 2'b00, 0, 8'd0, 1);
        add(0, 0, 2'b00, 0, 8'd0, 1);
        add(0, 0, 2'b00, 0, 8'd0, 1);
        add(0, 0, 2'b00, 0, 8'd0, 1);
        add(0, 1, 2'b11, 1, 8'd1, 0);
        add(0, 1, 2'b00, 0, 8'd1, 0);
        add(0, 0, 2'b00, 0, 8'd1, 0);
        // Early hit: press two edges after the note edge.
        add(1, 0, 2'b00, 0, 8'd1, 1);
        add(0, 0, 2'b00, 0, 8'd1, 1);
        add(0, 1, 2'b01, 1, 8'd2, 0);
        add(0, 0, 2'b00, 0, 8'd2, 0);
        // Miss: no press, expiry 10 ticks after entry.
        add(1, 0, 2'b00, 0, 8'd2, 1);
        for (int i = 0; i < 9; i++) add(0, 0, 2'b00, 0, 8'd2, 1);
        add(0, 0, 2'b00, 1, 8'd0, 0);
        add(0, 0, 2'b00, 0, 8'd0, 0);

        // Reset values, sampled while reset is still asserted.
        #12;
        check_out("reset", 2'b00, 1'b0, 8'd0, 1'b0);
        check("reset overrun_err", overrun_err, 0);
        @(negedge clk);
        reset = 1'b0;
        step();

        foreach (vecs[i]) begin
            note_valid = vecs[i].note;
            btn        = vecs[i].btn;
            step();
            check_out($sformatf("vec%0d", i), vecs[i].judge, vecs[i].jv, vecs[i].combo, vecs[i].busy);
        end
        note_valid = 1'b0;
        btn        = 1'b0;

        // Press coincident with the tick that would end LATE: judged 10, no miss.
        note_valid = 1'b1; step(); note_valid = 1'b0;
        repeat (9) step();
        check("late_last busy before press", busy, 1);
        btn = 1'b1; step();
        check_out("late_last hit", 2'b10, 1'b1, 8'd1, 1'b0);
        btn = 1'b0; step();
        check_out("late_last after", 2'b00, 1'b0, 8'd1, 1'b0);

        // Overlap: three consecutive notes; second queued, third dropped.
        check("overlap overrun before", overrun_err, 0);
        note_valid = 1'b1;
        repeat (3) step();
        note_valid = 1'b0;
        check("overlap overrun set", overrun_err, 1);
        repeat (7) step();
        check_out("overlap first open", 2'b00, 1'b0, 8'd1, 1'b1);
        step();
        check_out("overlap first miss", 2'b00, 1'b1, 8'd0, 1'b0);
        step();
        check_out("overlap second start", 2'b00, 1'b0, 8'd0, 1'b1);
        btn = 1'b1; step();
        check_out("overlap second early", 2'b01, 1'b1, 8'd1, 1'b0);
        btn = 1'b0;
        repeat (3) step();
        check("overlap no third window", busy, 0);
        check("overlap overrun sticky", overrun_err, 1);

        // Saturation: 256 perfect hits starting from combo=1.
        exp_combo = 8'd1;
        for (int k = 0; k < 256; k++) begin
            note_valid = 1'b1; step(); note_valid = 1'b0;
            repeat (4) step();
            btn = 1'b1; step();
            if (exp_combo != 8'hFF) exp_combo = exp_combo + 8'd1;
            check($sformatf("sat%0d judge", k), judge, 2'b11);
            check($sformatf("sat%0d judge_valid", k), judge_valid, 1);
            check($sformatf("sat%0d combo", k), combo, exp_combo);
            btn = 1'b0; step();
        end
        check("sat final combo", combo, 255);

        // Reset while in PERFECT aborts the window silently.
        note_valid = 1'b1; step(); note_valid = 1'b0;
        repeat (4) step();
        check("midreset busy before", busy, 1);
        #2 reset = 1'b1;
        #1;
        check_out("midreset", 2'b00, 1'b0, 8'd0, 1'b0);
        check("midreset overrun_err", overrun_err, 0);
        @(negedge clk);
        reset = 1'b0;
        jv_seen = 0;
        repeat (12) begin
            step();
            if (judge_valid) jv_seen++;
        end
        check("midreset no judge after", jv_seen, 0);

        // Hit, then a press in IDLE is ignored without penalty.
        note_valid = 1'b1; step(); note_valid = 1'b0;
        repeat (4) step();
        btn = 1'b1; step();
        check_out("post reset hit", 2'b11, 1'b1, 8'd1, 1'b0);
        btn = 1'b0; step();
        btn = 1'b1; step();
        check_out("idle press", 2'b00, 1'b0, 8'd1, 1'b0);
        btn = 1'b0; step();
        check_out("idle press after", 2'b00, 1'b0, 8'd1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hit_judge_ctrl.md
# hit_judge_ctrl

Timing-window judge and combo sequencer that drives the score accumulator in the rhythm-game datapath. For each note event it opens an early / perfect / late window timed in game ticks. It judges the first button press inside that window, or declares a miss when the window closes. Each result is issued as a one-cycle judgement code, together with the updated combo count, in exactly the encoding the score accumulator consumes every clock.

## Interface
- GOOD_WIN, 4: length in ticks of each "good" window (early and late); must be ≥1
- PERFECT_WIN, 2: length in ticks of the perfect window; must be ≥1
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- tick  in  1  game-rate enable pulse, one clk wide; window counters advance only on tick
- note_valid  in  1  one-cycle pulse: a note has reached the judge zone
- btn  in  1  debounced, clk-synchronous button level
- judge  out  2  00 none/miss, 01 good-early, 10 good-late, 11 perfect; 00 whenever judge_valid=0
- judge_valid  out  1  one-cycle strobe marking a judgement (including miss)
- combo  out  8  current consecutive-hit count, saturating at 255
- busy  out  1  high while a window is open (state ≠ IDLE)
- overrun_err  out  1  sticky: a note was dropped; cleared only by reset

## Operation
- States and encodings:
  - IDLE: no window open.
  - EARLY: press here judges 01.
  - PERFECT: press here judges 11.
  - LATE: press here judges 10; expiry here judges 00.
- Press edge detection:
  - btn_q is registered from btn; btn_q resets to 0.
  - press = btn & ~btn_q, evaluated every clk, not gated by tick.
- Window start:
  - In IDLE, note_valid or the pending flag moves the FSM to EARLY.
  - Window counter is cleared to 0 on entry.
  - If the transition was caused by the pending flag, pending is cleared.
- Window advance:
  - In EARLY, PERFECT and LATE, each tick increments the window counter.
  - tick with counter = limit−1 advances EARLY→PERFECT→LATE and clears the counter.
  - Limits: GOOD_WIN for EARLY and LATE, PERFECT_WIN for PERFECT.
  - tick with counter = GOOD_WIN−1 in LATE, and no press, produces a miss and returns to IDLE.
- Press inside a window:
  - Judge per the current state, then return to IDLE.
  - Only the first press counts; later presses in IDLE are ignored without penalty.
- Combo update:
  - A hit (01/10/11) sets combo = min(combo+1, 255).
  - A miss sets combo = 0.
  - combo updates on the same edge that raises judge_valid, so consumers sample the post-update value.
- Overlapping notes:
  - note_valid while state ≠ IDLE sets pending (one-deep queue).
  - note_valid while pending is already set is dropped and sets overrun_err.
- Window counter width: $clog2(max(GOOD_WIN, PERFECT_WIN)+1).

## Timing
- Reset values:
  - Outputs: judge=00, judge_valid=0, combo=0, busy=0, overrun_err=0.
  - Internal: state IDLE, pending=0, counter=0, btn_q=0.
- Reset mid-window aborts the window immediately; no judgement is emitted for the aborted note.
- Latency, note start: note_valid high at edge N in IDLE → busy=1 after edge N.
- Latency, press: btn rises before edge N, so press is seen at edge N → judge_valid/judge/combo valid for the cycle after edge N.
- Latency, miss: judge_valid is asserted for the cycle after the final LATE tick edge.
- judge_valid is exactly one cycle wide; judge returns to 00 the next cycle. This prevents repeated adds in the accumulator.
- Simultaneous press and window-advancing tick on the same edge: press wins and is judged with the pre-advance state. A press on the final LATE tick is therefore a 10 hit, not a miss.
- Simultaneous note_valid and judgement edge: the state is still ≠ IDLE, so note_valid sets pending.
- IDLE with pending set: EARLY is entered on the next edge, giving one IDLE cycle between windows.
- Earliest possible window: without press, a window spans 2·GOOD_WIN+PERFECT_WIN ticks.

## Configuration
- JUDGE_AUTOPLAY_EN defined:
  - btn is ignored and press is forced 0.
  - The FSM emits judge=11 on the first clk in PERFECT and returns to IDLE; this is demo/attract mode.
  - Combo rules are unchanged.
- JUDGE_AUTOPLAY_EN undefined: btn-driven judging exactly as described above.

## Test plan
All scenarios use GOOD_WIN=4, PERFECT_WIN=2, tick=1 every cycle.
- Perfect hit: note_valid, press 5 cycles after busy rises → judge_valid=1 for one cycle, judge=11, combo=1, busy=0 the cycle after.
- Early hit then miss: note → press 2 cycles later → judge=01, combo=1. Next note with no press → judge=00 exactly 10 ticks after entry, combo=0.
- Saturation: 256 consecutive perfect notes → combo reaches 255 and stays 255; judge=11 on every hit.
- Overlap: three note_valid pulses on consecutive cycles →
  - first window runs normally;
  - second starts one cycle after the first judgement;
  - third is dropped and overrun_err=1 and stays 1.
- Press on last LATE tick: press coincident with the tick ending LATE → judge=10, combo incremented, no miss emitted.
- Reset mid-window plus idle press: assert reset in PERFECT → all outputs 0 immediately, no judge_valid afterward. A press in IDLE → no judge_valid and combo unchanged.
